// File: rtl/wave_osc_if.sv
// Stream-side bundle for wave_osc: tuning/mode/duty controls in, samples out.
// The hard-sync input exists only when WAVE_OSC_SYNC_EN is defined.
interface wave_osc_if #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 16
);
    logic               i_tick;
    logic [PHASE_W-1:0] i_tune;
    logic [1:0]         i_mode;
    logic [PHASE_W-1:0] i_duty;
`ifdef WAVE_OSC_SYNC_EN
    logic               i_sync;
`endif
    logic [DATA_W-1:0]  o_data;
    logic               o_valid;
    logic               o_wrap;

    // Driver side: produces strobes/controls, consumes samples.
    modport master (
        output i_tick, i_tune, i_mode, i_duty,
`ifdef WAVE_OSC_SYNC_EN
        output i_sync,
`endif
        input  o_data, o_valid, o_wrap
    );

    // Oscillator side.
    modport slave (
        input  i_tick, i_tune, i_mode, i_duty,
`ifdef WAVE_OSC_SYNC_EN
        input  i_sync,
`endif
        output o_data, o_valid, o_wrap
    );
endinterface

// File: rtl/wave_osc.sv
// wave_osc: phase-accumulator oscillator producing square, saw, triangle or
// pulse samples (offset-binary) once per tick. The waveform selection is
// latched only at period boundaries so a mode change never produces a torn
// cycle. Optional hard sync is compiled in with macro WAVE_OSC_SYNC_EN.
module wave_osc #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    wave_osc_if.slave  bus
);

    localparam logic [DATA_W-1:0] MAX = '1;

    logic [PHASE_W-1:0] ph_q, ph_d;
    logic [1:0]         am_q, am_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               sync;

`ifdef WAVE_OSC_SYNC_EN
    assign sync = bus.i_sync;
`else
    assign sync = 1'b0;
`endif

    // Waveform shaping from the active mode and the phase before the update.
    function automatic logic [DATA_W-1:0] wave_f(
        input logic [1:0]         mode,
        input logic [PHASE_W-1:0] ph,
        input logic [PHASE_W-1:0] duty
    );
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] t;
        p = ph[PHASE_W-1 -: DATA_W];
        t = {p[DATA_W-2:0], 1'b0};
        case (mode)
            2'd0:    wave_f = ph[PHASE_W-1] ? '0 : MAX;
            2'd1:    wave_f = p;
            2'd2:    wave_f = p[DATA_W-1] ? ~t : t;
            default: wave_f = (ph < duty) ? MAX : '0;
        endcase
    endfunction

    // Carry out of the accumulator marks the period boundary.
    assign sum   = {1'b0, ph_q} + {1'b0, bus.i_tune};
    assign carry = bus.i_tick & sum[PHASE_W];

    // Next-state: advance on tick, latch mode on wrap, sync overrides phase.
    always_comb begin
        ph_d    = ph_q;
        am_d    = am_q;
        data_d  = data_q;
        valid_d = 1'b0;
        wrap_d  = carry;
        if (bus.i_tick) begin
            ph_d    = sum[PHASE_W-1:0];
            data_d  = wave_f(am_q, ph_q, bus.i_duty);
            valid_d = 1'b1;
        end
        if (sync) begin
            ph_d   = '0;
            wrap_d = 1'b1;
        end
        if (wrap_d) begin
            am_d = bus.i_mode;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ph_q    <= '0;
            am_q    <= bus.i_mode;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            am_q    <= am_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_wrap  = wrap_q;

endmodule

// File: doc/wave_osc.md
WAVE_OSC -- requirements
Module: wave_osc

Interface
REQ-001 The block SHALL have parameter PHASE_W, default 16, giving the phase accumulator and tuning word width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the sample width in bits; DATA_W <= PHASE_W and DATA_W >= 2.
REQ-003 Port i_clk  input  1  is the single system clock; all state updates on its rising edge.
REQ-004 Port i_rst_n  input  1  is the reset; it is synchronous and active-low.
REQ-005 Port i_tick  input  1  is the sample strobe; the oscillator advances one step per cycle where it is high.
REQ-006 Port i_tune  input  PHASE_W  is the phase increment per tick, unsigned.
REQ-007 Port i_mode  input  2  selects the waveform: 0 square, 1 saw, 2 triangle, 3 pulse.
REQ-008 Port i_duty  input  PHASE_W  is the pulse threshold, unsigned, used in mode 3 only.
REQ-009 Port o_data  output  DATA_W  is the registered sample, unsigned offset-binary.
REQ-010 Port o_valid  output  1  pulses high for one cycle when o_data is updated.
REQ-011 Port o_wrap  output  1  pulses high for one cycle when the accumulator carries out.

Function
REQ-012 The block SHALL hold phase register ph (PHASE_W bits) and active-mode register am (2 bits); P = ph[PHASE_W-1 -: DATA_W], MAX = 2^DATA_W-1.
REQ-013 On each edge with i_tick=1, the block SHALL set ph <= (ph + i_tune) mod 2^PHASE_W, o_data <= f(am, pre-update ph), and o_valid <= 1.
REQ-014 On each edge with i_tick=0, the block SHALL hold ph, am and o_data, and drive o_valid <= 0 and o_wrap <= 0.
REQ-015 The waveform f SHALL be: square = MAX if ph MSB=0, else 0; saw = P; triangle = T if P MSB=0, else ~T, where T = {P[DATA_W-2:0],1'b0}; pulse = MAX if ph < i_duty (unsigned), else 0.
REQ-016 o_wrap SHALL be 1 on the edge following a tick when ph + i_tune >= 2^PHASE_W.
REQ-017 On the same edge as a wrap, am SHALL load i_mode; at all other edges am SHALL hold, so mode changes take effect only at a period boundary.
REQ-018 With i_tune=0, ph SHALL hold and o_valid SHALL still pulse on each tick with a constant o_data.
REQ-019 i_duty=0 SHALL give pulse output 0 continuously; i_duty=2^PHASE_W-1 SHALL give MAX except when ph is all-ones.
REQ-020 Latency SHALL be one cycle from the i_tick edge to o_valid/o_data; throughput SHALL be one sample per cycle when i_tick is held high.

Reset
REQ-021 While i_rst_n=0 at an edge, the block SHALL set ph=0, am=i_mode, o_data=0, o_valid=0 and o_wrap=0, overriding all other inputs.
REQ-022 Reset asserted mid-period SHALL discard accumulated phase; the first tick after release SHALL output f(i_mode at reset, 0).

Configuration
REQ-023 With macro WAVE_OSC_SYNC_EN defined, the block SHALL add port i_sync  input  1  (hard sync).
REQ-024 With the macro defined, an edge with i_sync=1 SHALL set ph <= 0, load am <= i_mode and pulse o_wrap, whatever the value of i_tick.
REQ-025 With the macro defined, i_sync=1 with i_tick=1 SHALL still output f(am, pre-sync ph) with o_valid=1, and ph SHALL be 0, not i_tune.
REQ-026 Without the macro, i_sync SHALL not exist and phase SHALL change only through REQ-013 and REQ-021.

Verification
REQ-027 Reset, then mode 0, i_tune=0x4000, tick held high -> o_data = FFFF, FFFF, 0000, 0000 repeating; o_wrap on the 4th valid edge.
REQ-028 Mode 1, i_tune=0x1000, 16 ticks -> o_data = 0000, 1000, ... F000; one o_wrap pulse on the edge of the 16th tick.
REQ-029 Mode 2, i_tune=0x2000 -> o_data = 0000, 4000, 8000, C000, FFFF, BFFF, 7FFF, 3FFF.
REQ-030 Mode 3, i_duty=0x4000, i_tune=0x4000, with i_mode switched to 1 mid-period -> pulse pattern FFFF, 0000, 0000, 0000; saw starts only after the wrap.
REQ-031 i_tick toggling 1,0,0,1 -> o_valid high only on edges following a tick; o_data holds between them; i_rst_n=0 mid-run -> o_data=0 on the next edge.
REQ-032 With WAVE_OSC_SYNC_EN, ph=0x8000, i_sync=1 and i_tick=1 together -> o_data=f(0x8000), o_wrap=1; the next tick outputs f(0).
